uart_buf_tx: RTL and testbench



---
 rtl/uart_buf_tx.sv | 175 +++++++++++++++++
 tb/tb_uart_buf_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_buf_tx.sv
// ---------------------------------------------------------------------------
// uart_buf_tx
//
// Word-to-UART serializer. A 32-bit word is taken over a valid/ready
// handshake and sent as four 8N1 frames, least-significant byte first and
// each byte LSB first. A receiver that shifts every new byte in at the top
// of a 32-bit register rebuilds the original word.
//
// A one-word holding register sits in front of the serial engine. The next
// word can therefore be accepted while the current one is on the line. When
// the engine finishes a word and the holding register is full, the next word
// starts with no idle time on the line.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (>= 1). The default gives
//                  115200 baud from a 100 MHz clock.
//
// Ports
//   clk   : system clock; all logic runs on its rising edge.
//   rstn  : asynchronous active-low reset.
//   valid : data holds a word to send.
//   data  : word to transmit. It is sampled only on an accepting edge.
//   ready : holding register empty. A word is accepted on a rising edge
//           where valid && ready.
//   txd   : UART serial line, idle high, driven straight from a flop.
//   busy  : holding register full or a frame in progress.
// ---------------------------------------------------------------------------
module uart_buf_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid,
    input  logic [31:0] data,
    output logic        ready,
    output logic        txd,
    output logic        busy
);

    // The extra +1 keeps the width at least 1 bit when CLKS_PER_BIT == 1.
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_q;
    logic [31:0]         hold_q;
    logic                hold_full_q;
    logic                ready_q;
    logic [31:0]         shift_q;
    logic [1:0]          byte_cnt_q;
    logic [2:0]          bit_cnt_q;
    logic [BAUD_W-1:0]   baud_cnt_q;
    logic                txd_q;

    logic accept;
    logic bit_end;
    logic load_word;

    // ready_q always mirrors ~hold_full_q. Because of that, an accept and an
    // engine load can never fall on the same edge.
    assign accept  = valid && ready_q;
    assign bit_end = (baud_cnt_q == BAUD_LAST);

    // The engine takes a new word in two cases. The first is from IDLE. The
    // second is at the very end of the last stop bit of a word, so that
    // consecutive words run back to back.
    assign load_word = hold_full_q &&
                       ((state_q == IDLE) ||
                        (state_q == STOP && bit_end && byte_cnt_q == 2'd3));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            baud_cnt_q  <= '0;
            txd_q       <= 1'b1;
        end else begin
            if (accept) begin
                hold_q      <= data;
                hold_full_q <= 1'b1;
                ready_q     <= 1'b0;
            end

            // txd_q is loaded with the level of the bit being entered. The
            // line therefore changes on the same edge as the state does.
            case (state_q)
                IDLE: begin
                    txd_q      <= 1'b1;
                    baud_cnt_q <= '0;
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        state_q    <= DATA;
                        txd_q      <= shift_q[0];
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        shift_q    <= shift_q >> 1;
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            // shift_q[1] becomes shift_q[0] on this same edge.
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        if (byte_cnt_q != 2'd3) begin
                            // Eight shifts have already moved the next byte
                            // into shift_q[7:0].
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            state_q    <= START;
                            txd_q      <= 1'b0;
                        end else begin
                            // If the holding register is full, load_word
                            // overrides this return to IDLE below.
                            state_q <= IDLE;
                            txd_q   <= 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                end
            endcase

            // Placed last so that it wins over the STOP end-of-word branch.
            if (load_word) begin
                shift_q     <= hold_q;
                byte_cnt_q  <= '0;
                bit_cnt_q   <= '0;
                baud_cnt_q  <= '0;
                hold_full_q <= 1'b0;
                ready_q     <= 1'b1;
                state_q     <= START;
                txd_q       <= 1'b0;
            end
        end
    end

    assign ready = ready_q;
    assign txd   = txd_q;
    assign busy  = hold_full_q || (state_q != IDLE);

endmodule

// File: tb/tb_uart_buf_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_buf_tx
//
// Directed bench for uart_buf_tx. Two instances are used: one with
// CLKS_PER_BIT=4 for most cases and one with CLKS_PER_BIT=1 for the
// single-cycle-bit case. Inputs are driven on falling edges, and outputs are
// sampled on falling edges. A small serial receiver task rebuilds words from
// txd for the loopback and backpressure cases.
// ---------------------------------------------------------------------------
module tb_uart_buf_tx;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid4, valid1;
    logic [31:0] data4, data1;
    logic        ready4, txd4, busy4;
    logic        ready1, txd1, busy1;

    always #5 clk = ~clk;

    uart_buf_tx #(.CLKS_PER_BIT(C)) dut4 (
        .clk   (clk),
        .rstn  (rstn),
        .valid (valid4),
        .data  (data4),
        .ready (ready4),
        .txd   (txd4),
        .busy  (busy4)
    );

    uart_buf_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk   (clk),
        .rstn  (rstn),
        .valid (valid1),
        .data  (data1),
        .ready (ready1),
        .txd   (txd1),
        .busy  (busy1)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    logic cap_txd  [0:511];
    logic cap_rdy  [0:511];
    logic cap_busy [0:511];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Present a word on dut4 and return at the falling edge right after the
    // accepting rising edge E, i.e. at E + half a cycle.
    task automatic send4(input logic [31:0] w);
        int t = 0;
        @(negedge clk);
        valid4 = 1'b1;
        data4  = w;
        while (ready4 !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("send_timeout", 64'(t), 64'd0);
        @(negedge clk);
        valid4 = 1'b0;
        data4  = '0;
        $display("tx word %08h accepted", w);
    endtask

    // Sample index i corresponds to the falling edge after rising edge E+1+i.
    task automatic capture4(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_txd[i]  = txd4;
            cap_rdy[i]  = ready4;
            cap_busy[i] = busy4;
        end
    endtask

    // Compare each captured frame with {stop, byte, start}. Every cycle of
    // every bit must hold the expected level.
    task automatic verify_frames(input string tag, input logic [31:0] w0,
                                 input logic [31:0] w1, input int nframes);
        logic [63:0] words;
        logic [7:0]  b;
        logic [9:0]  obs, exp_f;
        int          mism;
        words = {w1, w0};
        for (int f = 0; f < nframes; f++) begin
            b     = words[f*8 +: 8];
            exp_f = {1'b1, b, 1'b0};
            mism  = 0;
            for (int k = 0; k < 10; k++) begin
                obs[k] = cap_txd[f*10*C + k*C + C/2];
                for (int j = 0; j < C; j++)
                    if (cap_txd[f*10*C + k*C + j] !== exp_f[k]) mism++;
            end
            check($sformatf("%s.frame%0d", tag, f), 64'(obs), 64'(exp_f));
            check($sformatf("%s.cycles%0d", tag, f), 64'(mism), 64'd0);
        end
    endtask

    // Serial receiver for dut4: find the start bit, move to mid-bit, then
    // sample eight data bits and the stop bit.
    task automatic rx_byte(output logic [7:0] b);
        int t = 0;
        b = '0;
        @(negedge clk);
        while (txd4 !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            check("rx_start_timeout", 64'(t), 64'd0);
        end else begin
            repeat (C/2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (C) @(negedge clk);
                b[k] = txd4;
            end
            repeat (C) @(negedge clk);
            check("rx_stop_bit", 64'(txd4), 64'd1);
        end
    endtask

    task automatic rx_word(output logic [31:0] w);
        logic [7:0] b;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            rx_byte(b);
            w = {b, w[31:8]};
        end
        $display("rx word %08h", w);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rw;
        logic [39:0] obs1;
        int          zeros;
        logic        busy_last1, busy_end1;

        rstn   = 1'b1;
        valid4 = 1'b0;
        valid1 = 1'b0;
        data4  = '0;
        data1  = '0;

        // Power-on reset.
        #2 rstn = 1'b0;
        #1;
        check("por.txd",   64'(txd4),   64'd1);
        check("por.ready", 64'(ready4), 64'd1);
        check("por.busy",  64'(busy4),  64'd0);
        check("por.txd1",  64'(txd1),   64'd1);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Single word. Four frames over 160 cycles; busy falls 160 cycles
        // after the load edge E+1.
        send4(32'h44332211);
        check("w1.txd_at_accept", 64'(txd4),   64'd1);
        check("w1.ready_drop",    64'(ready4), 64'd0);
        check("w1.busy_rise",     64'(busy4),  64'd1);
        capture4(170);
        verify_frames("w1", 32'h44332211, 32'h0, 4);
        check("w1.ready_back", 64'(cap_rdy[0]),    64'd1);
        check("w1.busy_159",   64'(cap_busy[159]), 64'd1);
        check("w1.busy_160",   64'(cap_busy[160]), 64'd0);

        // Back-to-back words. The second word is accepted at E+12 and waits
        // in the holding register until E+161.
        send4(32'hDEADBEEF);
        fork
            capture4(330);
            begin
                repeat (10) @(negedge clk);
                send4(32'h01234567);
            end
        join
        verify_frames("b2b", 32'hDEADBEEF, 32'h01234567, 8);
        check("b2b.ready_pre",  64'(cap_rdy[10]),   64'd1);
        check("b2b.ready_held", 64'(cap_rdy[11]),   64'd0);
        check("b2b.ready_159",  64'(cap_rdy[159]),  64'd0);
        check("b2b.ready_160",  64'(cap_rdy[160]),  64'd1);
        check("b2b.busy_319",   64'(cap_busy[319]), 64'd1);
        check("b2b.busy_320",   64'(cap_busy[320]), 64'd0);

        // Backpressure. valid stays high while data changes every cycle.
        // Accepts happen on edges 0, 2 and 162.
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk);
                    valid4 = 1'b1;
                    data4  = 32'hA000_0000 + 32'(k);
                end
                @(negedge clk);
                valid4 = 1'b0;
                data4  = '0;
            end
            begin
                rx_word(rw);
                check("bp.word0", 64'(rw), 64'hA000_0000);
                rx_word(rw);
                check("bp.word1", 64'(rw), 64'hA000_0002);
                rx_word(rw);
                check("bp.word2", 64'(rw), 64'hA000_00A2);
            end
        join
        repeat (4*C) @(negedge clk);
        check("bp.no_extra_word", 64'(busy4), 64'd0);

        // Loopback into the serial receiver.
        fork
            begin
                send4(32'hCAFEF00D);
                send4(32'h00000000);
            end
            begin
                rx_word(rw);
                check("lb.word0", 64'(rw), 64'hCAFEF00D);
                rx_word(rw);
                check("lb.word1", 64'(rw), 64'h00000000);
            end
        join
        repeat (4*C) @(negedge clk);

        // Reset in the middle of a frame. Sample index 5 falls in data bit 0
        // of byte 0x00, so txd is low just before reset.
        send4(32'h00000000);
        repeat (6) @(negedge clk);
        check("rst.pre_txd", 64'(txd4), 64'd0);
        #1 rstn = 1'b0;
        #1;
        check("rst.txd",   64'(txd4),   64'd1);
        check("rst.ready", 64'(ready4), 64'd1);
        check("rst.busy",  64'(busy4),  64'd0);
        @(negedge clk);
        rstn = 1'b1;
        capture4(60);
        zeros = 0;
        for (int i = 0; i < 60; i++)
            if (cap_txd[i] !== 1'b1) zeros++;
        check("rst.no_stray_start", 64'(zeros),        64'd0);
        check("rst.busy_after",     64'(cap_busy[59]), 64'd0);
        $display("reset mid-frame done");

        // CLKS_PER_BIT=1. The line reads 0,1,0,1,0,0,1,0,1,1, followed by
        // three frames of zero bytes.
        @(negedge clk);
        valid1 = 1'b1;
        data1  = 32'h000000A5;
        check("c1.ready", 64'(ready1), 64'd1);
        @(negedge clk);
        valid1 = 1'b0;
        data1  = '0;
        $display("tx word 000000a5 accepted (1 clk/bit)");
        busy_last1 = 1'b0;
        busy_end1  = 1'b0;
        for (int i = 0; i < 41; i++) begin
            @(negedge clk);
            if (i < 40) obs1[i] = txd1;
            if (i == 39) busy_last1 = busy1;
            if (i == 40) busy_end1  = busy1;
        end
        check("c1.pattern", 64'(obs1), 64'h80_2008_034A);
        check("c1.busy_39", 64'(busy_last1), 64'd1);
        check("c1.busy_40", 64'(busy_end1),  64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
